// File: rtl/tick_mon_pkg.sv
// tick_mon_pkg: shared state encoding and interval window check for tick_period_monitor
package tick_mon_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_e;
  function automatic logic in_window(input int iv, input int exp_p, input int tol);
    return iv >= exp_p - tol && iv <= exp_p + tol;
  endfunction
endpackage

// File: rtl/tick_interval_cnt.sv
// tick_interval_cnt: interval counter, period capture and one-shot timeout for tick_period_monitor
module tick_interval_cnt #(
  parameter int CNT_W = 8,
  parameter int EXP_PERIOD = 4,
  parameter int TOL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             active_i,
  output logic [CNT_W-1:0] iv_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_vld_o,
  output logic             evt_o,
  output logic             to_o
);
  localparam logic [CNT_W-1:0] TO_AT = CNT_W'(EXP_PERIOD + TOL);
  logic [CNT_W-1:0] iv_q, iv_d, period_q;
  logic vld_q, to_fired_q, to_fired_d;
  // a tick closing an interval that already timed out is measured but not judged again
  assign evt_o = active_i && tick_i && !to_fired_q;
  assign to_o = active_i && !tick_i && !to_fired_q && iv_q == TO_AT;
  assign iv_o = iv_q;
  assign period_o = period_q;
  assign period_vld_o = vld_q;
  always_comb iv_d = tick_i ? CNT_W'(1) : (active_i && iv_q != '1) ? iv_q + 1'b1 : iv_q;
  always_comb to_fired_d = tick_i ? 1'b0 : to_o ? 1'b1 : to_fired_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      iv_q <= '0;
      period_q <= '0;
      vld_q <= 1'b0;
      to_fired_q <= 1'b0;
    end else begin
      iv_q <= iv_d;
      to_fired_q <= to_fired_d;
      vld_q <= tick_i && active_i;
      if (tick_i && active_i) period_q <= iv_q;
    end
  end
endmodule

// File: rtl/tick_period_monitor.sv
// tick_period_monitor: checks strobe intervals against EXP_PERIOD, tracks lock and counts errors
module tick_period_monitor
  import tick_mon_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int EXP_PERIOD = 4,
  parameter int TOL = 0,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             clr_err,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int GR_W = $clog2(LOCK_CNT + 1);
  state_e state_q;
  logic [GR_W-1:0] good_run_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] iv;
  logic locked_q, err_pulse_q, evt, to, good, err, last;
  tick_interval_cnt #(.CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL)) u_cnt (
    .clk(clk),
    .rst(rst),
    .tick_i(tick_in),
    .active_i(state_q != IDLE),
    .iv_o(iv),
    .period_o(period),
    .period_vld_o(period_vld),
    .evt_o(evt),
    .to_o(to)
  );
  assign good = evt && in_window(int'(iv), EXP_PERIOD, TOL);
  assign err = to || (evt && !good);
  assign last = int'(good_run_q) + 1 == LOCK_CNT;
  assign locked = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt = err_cnt_q;
  always_comb err_cnt_d = clr_err ? '0 : (err && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      good_run_q <= '0;
      locked_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_pulse_q <= err;
      err_cnt_q <= err_cnt_d;
      case (state_q)
        IDLE: begin
          locked_q <= 1'b0;
          if (tick_in) begin
            state_q <= ACQUIRE;
            good_run_q <= '0;
          end
        end
        ACQUIRE: begin
          locked_q <= good && last;
          if (err) good_run_q <= '0;
          else if (good && last) begin
            state_q <= LOCKED;
            good_run_q <= '0;
          end else if (good) good_run_q <= good_run_q + 1'b1;
        end
        LOCKED: begin
          locked_q <= !err;
          if (err) begin
            state_q <= ACQUIRE;
            good_run_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/tick_period_monitor.md
Name: tick_period_monitor

Overview:
- Receive-side checker for single-cycle enable strobes produced by the team's clock-divider/flag generators, all in the same clk domain.
- Measures the cycle interval between consecutive strobes and compares it against the expected divide ratio.
- Declares lock after a run of good intervals, and flags and counts short, long or missing strobes.
- Sits beside any divided-enable consumer as a health monitor.

Parameters:
- CNT_W, 8, width of the interval counter and the period output.
- EXP_PERIOD, 4, expected strobe interval in clk cycles; legal range 2..2^CNT_W-2.
- TOL, 0, allowed absolute deviation; EXP_PERIOD+TOL must be ≤ 2^CNT_W-2.
- LOCK_CNT, 4, consecutive good intervals required to lock; must be ≥ 1.
- ERR_W, 8, width of the error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high; clock is clk.
- tick_in  in  1  single-cycle strobe under test, sampled every clk.
- clr_err  in  1  synchronous clear of err_cnt.
- locked  out  1  high while in LOCKED.
- period  out  CNT_W  last measured interval.
- period_vld  out  1  one-cycle pulse when period updates.
- err_pulse  out  1  one-cycle pulse per detected error.
- err_cnt  out  ERR_W  saturating error count.

Behaviour:
- Reset values: all outputs 0, iv_cnt=0, good_run=0, state=IDLE, to_fired=0.
- All outputs are registered. An event sampled in cycle t is visible in cycle t+1.
- Interval counter iv_cnt:
  - On tick_in: iv_cnt<=1.
  - Otherwise, if not IDLE: iv_cnt<=iv_cnt+1, saturating at 2^CNT_W-1.
- Measurement: on tick_in when state≠IDLE, period<=iv_cnt and period_vld<=1. Example: ticks every 4 cycles give period=4.
- Good interval: EXP_PERIOD-TOL ≤ iv_cnt ≤ EXP_PERIOD+TOL. Any other interval is bad.
- Timeout: state≠IDLE, tick_in=0, iv_cnt==EXP_PERIOD+TOL, to_fired=0.
  - Raises an error and sets to_fired=1.
  - The next tick clears to_fired. That closing long interval still updates period but does not raise a second error.
- FSM:
  - IDLE: first tick -> ACQUIRE with good_run=0. No measurement is made.
  - ACQUIRE, good interval: good_run++. If good_run+1==LOCK_CNT -> LOCKED and good_run=0.
  - ACQUIRE, bad interval or timeout: error, good_run=0, stay in ACQUIRE.
  - LOCKED, good interval: stay in LOCKED.
  - LOCKED, bad interval or timeout: error, -> ACQUIRE with good_run=0.
  - Unused encodings -> IDLE.
- Error: err_pulse<=1 for one cycle. err_cnt increments, saturating at 2^ERR_W-1 with no wrap.
- clr_err: err_cnt<=0.
  - If an error occurs in the same cycle, clr_err wins and err_cnt=0.
  - err_pulse still asserts for that error.
- Tick and timeout condition in the same cycle: the tick wins. It is treated as a measured interval with no timeout.
- Reset mid-operation: everything returns to reset values at the next edge. The first tick after reset only re-arms the block (-> ACQUIRE).

Decomposition:
- Shared package tick_mon_pkg holds:
  - the state enum IDLE/ACQUIRE/LOCKED (2-bit);
  - the good-interval compare helper function.
- One sub-module, tick_interval_cnt, contains:
  - the iv_cnt saturating counter;
  - the period/period_vld capture;
  - the timeout/to_fired logic.
- The top level holds the FSM, good_run and the error counter.

Test Plan:
- Lock-in: defaults, tick_in at cycles 0, 4, 8, 12, 16 -> period=4 with period_vld at cycles 5, 9, 13, 17; locked=1 from cycle 17; err_cnt=0.
- Missing tick: lock as above, then no tick after 16 -> err_pulse at cycle 21; locked=0 at cycle 21; err_cnt=1. A tick at cycle 24 -> period=8 at cycle 25, no second error.
- Short interval: locked, then tick at cycle 19 instead of 20 -> period=3, err_pulse=1, locked=0 at cycle 20. Four further 4-cycle intervals -> relock.
- TOL=1: intervals 3, 5, 4, 5 -> all good, locked after the 4th; an interval of 6 -> timeout error at iv_cnt==5.
- Saturation/clear: ERR_W=2, force 5 errors -> err_cnt holds 3. clr_err coincident with an error -> err_cnt=0 and err_pulse=1.
- Reset mid-lock: rst high for 1 cycle while locked -> all outputs 0 next cycle. The first subsequent tick gives no period_vld.
